// File: rtl/dm_word_arbiter.sv
// Round-robin arbiter that serialises 32-bit word accesses from two ports into big-endian byte beats on a 64-byte RAM.
// Build option: define DM_FIXED_PRIORITY_EN to make port 0 win every tie (port 1 may starve).
module dm_word_arbiter #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [31:0]       p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [31:0]       p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

  state_e              state_q,    state_d;
  logic [1:0]          beat_q,     beat_d;
  logic                owner_q,    owner_d;
  logic                we_q,       we_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic [31:0]         wdata_q,    wdata_d;
  logic                err_q,      err_d;
  logic [31:0]         rdata_q,    rdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
`ifdef DM_FIXED_PRIORITY_EN
`else
  logic                last_owner_q, last_owner_d;
`endif

  logic                grant1;
  logic [31:0]         sel_addr;
  logic [ADDR_W-1:0]   xfer_addr;
  logic [7:0]          beat_byte;

`ifdef DM_FIXED_PRIORITY_EN
  assign grant1 = !p0_req;
`else
  // On a tie the port that was not served last wins.
  assign grant1 = p1_req && (!p0_req || !last_owner_q);
`endif

  assign sel_addr  = grant1 ? p1_addr : p0_addr;
  assign xfer_addr = addr_q + ADDR_W'(beat_q);

  always_comb begin
    beat_byte = wdata_q[31:24];
    case (beat_q)
      2'd0: beat_byte = wdata_q[31:24];
      2'd1: beat_byte = wdata_q[23:16];
      2'd2: beat_byte = wdata_q[15:8];
      2'd3: beat_byte = wdata_q[7:0];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    mem_addr_d   = mem_addr_q;
`ifdef DM_FIXED_PRIORITY_EN
`else
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          owner_d = grant1;
          we_d    = grant1 ? p1_we : p0_we;
          addr_d  = sel_addr[ADDR_W-1:0];
          wdata_d = grant1 ? p1_wdata : p0_wdata;
`ifdef DM_FIXED_PRIORITY_EN
`else
          last_owner_d = grant1;
`endif
          if ((sel_addr[1:0] != 2'b00) || (sel_addr > (DEPTH - 32'd4))) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            beat_d  = '0;
            state_d = XFER;
          end
        end
      end
      XFER: begin
        mem_addr_d = xfer_addr;
        beat_d     = beat_q + 2'd1;
        if (!we_q) rdata_d = {rdata_q[23:0], mem_rdata};
        if (beat_q == 2'd3) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      mem_addr_q   <= '0;
`ifdef DM_FIXED_PRIORITY_EN
`else
      last_owner_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      mem_addr_q   <= mem_addr_d;
`ifdef DM_FIXED_PRIORITY_EN
`else
      last_owner_q <= last_owner_d;
`endif
    end
  end

  // The address is live only while beating; otherwise the last beat address is held.
  assign mem_addr  = (state_q == XFER) ? xfer_addr : mem_addr_q;
  assign mem_we    = (state_q == XFER) && we_q;
  assign mem_wdata = (state_q == XFER) ? beat_byte : '0;
  assign busy      = (state_q != IDLE);
  assign rdata     = rdata_q;
  assign p0_ack    = (state_q == DONE) && !owner_q;
  assign p1_ack    = (state_q == DONE) &&  owner_q;
  assign p0_err    = p0_ack && err_q;
  assign p1_err    = p1_ack && err_q;

endmodule

// File: tb/tb_dm_word_arbiter.sv
// Randomised bench for dm_word_arbiter against a word-level memory and arbitration model.
module tb_dm_word_arbiter;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;
`ifdef DM_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              Reset = 1'b0;
  logic              p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [31:0]       p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
  logic              p0_ack, p0_err, p1_ack, p1_err, mem_we, busy;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, mem_rdata;

  logic [7:0]  ram     [DEPTH];
  logic [7:0]  ref_mem [DEPTH];
  int          ref_last  = 1;
  logic [31:0] ref_rdata = '0;
  int          n_checks  = 0;
  int          n_fail    = 0;

  always #5 CLK = ~CLK;

  dm_word_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .Reset(Reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  assign mem_rdata = ram[mem_addr];
  always @(posedge CLK) if (mem_we) ram[mem_addr] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit addr_err(input logic [31:0] a);
    return (a % 4 != 0) || (a > DEPTH - 4);
  endfunction

  // Word-level effect of one access on the reference memory and read register.
  task automatic model_xfer(input bit we, input logic [31:0] a, input logic [31:0] d,
                            output bit err, output logic [31:0] rd);
    err = addr_err(a);
    if (!err) begin
      if (we) begin
        for (int i = 0; i < 4; i++) ref_mem[int'(a) + i] = 8'(d >> (24 - 8 * i));
      end else begin
        ref_rdata = {ref_mem[int'(a)], ref_mem[int'(a) + 1], ref_mem[int'(a) + 2], ref_mem[int'(a) + 3]};
      end
    end
    rd = ref_rdata;
  endtask

  task automatic wait_ack(input int port, output int lat);
    lat = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge CLK); #1;
      lat++;
      if ((port == 0 && p0_ack) || (port == 1 && p1_ack)) return;
    end
    lat = -1;
  endtask

  task automatic run_pair(input bit r0, input bit r1, input bit we0, input bit we1,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1);
    int order [2];
    bit e [2];
    logic [31:0] rd [2];
    int lat_exp [2];
    int n, exp_we, served, lat, we_cnt, got, p;
    @(posedge CLK); #1;
    check("idle_busy", busy, 0);
    if (r0 && r1) begin
      order[0] = FIXED ? 0 : ((ref_last == 1) ? 0 : 1);
      order[1] = 1 - order[0];
      n = 2;
    end else begin
      order[0] = r1 ? 1 : 0;
      order[1] = 0;
      n = 1;
    end
    exp_we = 0;
    for (int i = 0; i < n; i++) begin
      p = order[i];
      model_xfer(p ? we1 : we0, p ? a1 : a0, p ? d1 : d0, e[i], rd[i]);
      lat_exp[i] = (e[i] ? 1 : 5) + (i > 0 ? 1 : 0);
      if (!e[i] && (p ? we1 : we0)) exp_we += 4;
      ref_last = p;
    end
    p0_req = r0; p0_we = we0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
    served = 0; lat = 0; we_cnt = 0;
    for (int cyc = 0; cyc < 40 && served < n; cyc++) begin
      @(posedge CLK); #1;
      lat++;
      if (mem_we) we_cnt++;
      if (p0_ack || p1_ack) begin
        got = p1_ack ? 1 : 0;
        check("dual_ack", p0_ack && p1_ack, 0);
        check("grant", got, order[served]);
        check("err", got ? p1_err : p0_err, e[served]);
        check("other_err", got ? p0_err : p1_err, 0);
        check("rdata", rdata, rd[served]);
        check("latency", lat, lat_exp[served]);
        if (got == 1) p1_req = 1'b0; else p0_req = 1'b0;
        served++;
        lat = 0;
      end
    end
    check("served", served, n);
    check("we_beats", we_cnt, exp_we);
    p0_req = 1'b0; p1_req = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge CLK); Reset = 1'b0;
    @(negedge CLK); Reset = 1'b1;
    ref_last = 1; ref_rdata = '0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'($urandom_range(0, 63));
      1:       return 32'($urandom_range(16, 1000)) * 4;
      default: return 32'($urandom_range(0, 15)) * 4;
    endcase
  endfunction

  initial begin
    int lat;
    bit e;
    logic [31:0] rd, x, m;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    #1;
    check("rst_busy", busy, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_rdata", rdata, 0);
    check("rst_acks", {p0_ack, p0_err, p1_ack, p1_err}, 0);
    @(negedge CLK); @(negedge CLK); Reset = 1'b1;

    run_pair(1, 0, 1, 0, 32'h08, 0, 32'hDEADBEEF, 0);
    check("ram8", ram[8], 8'hDE);
    check("ram9", ram[9], 8'hAD);
    check("ram10", ram[10], 8'hBE);
    check("ram11", ram[11], 8'hEF);
    run_pair(0, 1, 0, 0, 0, 32'h08, 0, 0);

    pulse_reset();
    run_pair(1, 1, 1, 0, 32'h20, 32'h08, 32'h01020304, 0);
    run_pair(1, 1, 0, 0, 32'h20, 32'h24, 0, 0);

    run_pair(1, 0, 0, 0, 32'h05, 0, 0, 0);
    run_pair(1, 0, 1, 0, 32'h3E, 0, 32'hFFFFFFFF, 0);
    run_pair(0, 1, 1, 0, 0, 32'h3C, 0, 0);

    // Back-to-back: p0 keeps req high through the ack cycle with a new request.
    @(posedge CLK); #1;
    x = $urandom;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h30; p0_wdata = x;
    model_xfer(1'b1, 32'h30, x, e, rd);
    wait_ack(0, lat);
    check("b2b_lat1", lat, 5);
    p0_we = 1'b0;
    model_xfer(1'b0, 32'h30, 0, e, rd);
    ref_last = 0;
    @(posedge CLK); #1;
    check("b2b_idle", busy, 0);
    check("b2b_noack", p0_ack, 0);
    @(posedge CLK); #1;
    check("b2b_busy", busy, 1);
    wait_ack(0, lat);
    check("b2b_lat2", lat, 4);
    check("b2b_rdata", rdata, x);
    p0_req = 1'b0;

    // Reset after the second byte of a write has landed.
    @(posedge CLK); #1;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h10; p0_wdata = 32'h11223344;
    repeat (3) @(posedge CLK);
    #1; Reset = 1'b0; #1;
    check("mid_busy", busy, 0);
    check("mid_mem_we", mem_we, 0);
    check("mid_ack", p0_ack, 0);
    check("mid_rdata", rdata, 0);
    check("mid_mem_addr", 32'(mem_addr), 0);
    p0_req = 1'b0;
    check("mid_ram10", ram[16], 8'h11);
    check("mid_ram11", ram[17], 8'h22);
    check("mid_ram12", ram[18], ref_mem[18]);
    check("mid_ram13", ram[19], ref_mem[19]);
    ref_mem[16] = 8'h11; ref_mem[17] = 8'h22;
    @(negedge CLK); Reset = 1'b1;
    ref_last = 1; ref_rdata = '0;
    m = '0;
    repeat (3) begin @(posedge CLK); #1; m = m | {30'b0, p1_ack, p0_ack}; end
    check("mid_noack", m, 0);

    for (int t = 0; t < 150; t++) begin
      int mask;
      mask = $urandom_range(1, 3);
      run_pair(mask[0], mask[1], 1'($urandom), 1'($urandom),
               rand_addr(), rand_addr(), $urandom, $urandom);
    end

    for (int i = 0; i < int'(DEPTH); i++) check("ram_final", ram[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
